stack_seq_controller: RTL and testbench
=======================================

# stack_seq_controller

Sequencer for all stack traffic leaving the execute stage. It accepts one stack request at a time (PUSH, POP, 32-bit CALL/INT push, 32-bit RET/RTI pop) and splits 32-bit requests into two 16-bit memory transactions. It drives the SP_OP/Enable controls of the stack-pointer block once per completed word and stalls the front of the pipeline while a request is in flight. It sits between the execute stage and the data-memory port.

## Interface
Parameters:
- SP_TOP, 32'h0000_0FFF: highest legal stack address; used only under the bound-check configuration.
- SP_LIMIT, 32'h0000_0800: lowest legal stack address; used only under the bound-check configuration.

Ports:
- CLK  in  1  clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high.
- Req  in  1  stack request valid; accepted only when Ready=1.
- ReqOp  in  2  00 PUSH16, 01 POP16, 10 PUSH32, 11 POP32.
- ReqData  in  32  push data; PUSH16 uses [15:0].
- SPValue  in  32  current SP from the stack-pointer block.
- Ready  out  1  1 in IDLE only.
- Stall  out  1  1 whenever state≠IDLE.
- MemReq  out  1  memory transaction valid.
- MemWrite  out  1  1 = write, 0 = read; meaningful only with MemReq.
- MemAddr  out  32  word address.
- MemWData  out  16  write data.
- MemAck  in  1  transaction complete; honoured only while MemReq=1.
- MemRData  in  16  read data, valid with MemAck.
- SP_OP  out  2  00 hold, 01 decrement, 10 increment.
- SPEnable  out  1  one-cycle pulse that applies SP_OP.
- PopData  out  32  popped value; POP16 zero-extends.
- Done  out  1  one-cycle completion pulse.
- StackErr  out  1  one-cycle error pulse, coincident with Done.

## Operation
- FSM states: IDLE, XFER0, XFER1, DONE.
- IDLE:
  - On Req=1, latch ReqOp, ReqData and Base=SPValue, then go to XFER0.
  - No other request is accepted until the FSM is back in IDLE.
- Stack grows down:
  - Push writes at SP, then decrements SP.
  - Pop increments SP, then reads at the new SP.
- Addresses are computed from the latched Base, never from live SPValue:
  - Push word k (k=0,1): MemAddr = Base − k.
  - Pop word k: MemAddr = Base + 1 + k.
- Word order:
  - PUSH32 writes ReqData[31:16] at word 0 and ReqData[15:0] at word 1.
  - POP32 reads the low half at word 0 and the high half at word 1.
- XFERn:
  - Hold MemReq=1 with MemAddr, MemWData and MemWrite stable until MemAck.
  - In the MemAck cycle, pulse SPEnable with SP_OP = 01 (push) or 10 (pop).
  - Pop: capture MemRData into the proper half of PopData.
  - Then go to XFER1 (32-bit op from XFER0) or DONE.
- DONE: Done=1 for one cycle, then go to IDLE.
- PopData holds its value until the next pop capture.
- Outside the MemAck cycle, SP_OP=00 and SPEnable=0.
- Any ReqOp value is legal; there is no illegal-op state.

## Timing
- Reset values (the next edge with Reset=1 forces these regardless of state):
  - State IDLE, Ready=1.
  - Stall, MemReq, MemWrite, SPEnable, Done, StackErr = 0.
  - MemAddr=0, MemWData=0, PopData=0, SP_OP=00.
- Reset mid-operation:
  - MemReq drops on the reset edge.
  - No SPEnable pulse is issued.
  - A partially completed 32-bit op leaves SP moved by only the words already acknowledged.
- Accept at edge t; MemReq=1 from cycle t+1.
- MemAck may arrive in the first MemReq cycle (zero wait).
- Minimum latency from accept to Done:
  - 16-bit op: 2 cycles (XFER0, DONE).
  - 32-bit op: 3 cycles (XFER0, XFER1, DONE).
- MemReq deasserts for at least zero cycles between XFER0 and XFER1; back-to-back words are allowed.
- Ready and Stall are registered state decodes, so there is no combinational path from Req.
- SPEnable is asserted in the same cycle as MemAck. The stack-pointer block updates on the following edge.

## Configuration
- STACK_BOUND_CHECK_EN defined:
  - On accept, check the request range:
    - Push: Base − (words−1) < SP_LIMIT is an error.
    - Pop: Base + words > SP_TOP is an error.
  - On error: go directly IDLE→DONE; assert Done and StackErr together.
  - On error: no MemReq, no SPEnable, PopData unchanged.
- STACK_BOUND_CHECK_EN undefined:
  - No check; StackErr is tied 0; SP_TOP and SP_LIMIT are unused.

## Test plan
- Reset held 2 cycles, then released → Ready=1, all other outputs at their reset values.
- PUSH16, SPValue=0x0FFF, ReqData=0x0000_ABCD, MemAck immediate → one write of 0xABCD to 0x0FFF, SPEnable with SP_OP=01 once, Done 2 cycles after accept.
- PUSH32, SPValue=0x0FFF, ReqData=0x1234_5678, MemAck after 2 wait cycles per word → write 0x1234 to 0x0FFF, then 0x5678 to 0x0FFE, two decrement pulses, Stall=1 throughout.
- POP32, SPValue=0x0FFD, reads return 0x5678 then 0x1234 → addresses 0x0FFE then 0x0FFF, two increment pulses, PopData=0x1234_5678 at Done.
- PUSH32 with Reset asserted while waiting in XFER1 → MemReq=0 next cycle, exactly one SPEnable pulse total, Ready=1 after reset.
- With STACK_BOUND_CHECK_EN: POP16 at SPValue=0x0FFF → Done and StackErr together 1 cycle after accept, no MemReq, no SPEnable. Without the macro: the same stimulus reads 0x1000 and StackErr=0.

Source files
------------

// File: rtl/stack_seq_controller_if.sv
// Stack sequencer bus: execute-stage request side plus the data-memory
// port and the stack-pointer control outputs.
// The sequencer uses the master modport; the execute stage, memory and
// stack-pointer block together form the slave side.
interface stack_seq_controller_if;
  // Request from execute stage
  logic        Req;
  logic [1:0]  ReqOp;
  logic [31:0] ReqData;
  logic [31:0] SPValue;
  logic        Ready;
  logic        Stall;

  // Data-memory port
  logic        MemReq;
  logic        MemWrite;
  logic [31:0] MemAddr;
  logic [15:0] MemWData;
  logic        MemAck;
  logic [15:0] MemRData;

  // Stack-pointer block controls and completion status
  logic [1:0]  SP_OP;
  logic        SPEnable;
  logic [31:0] PopData;
  logic        Done;
  logic        StackErr;

  modport master (
    input  Req, ReqOp, ReqData, SPValue, MemAck, MemRData,
    output Ready, Stall, MemReq, MemWrite, MemAddr, MemWData,
           SP_OP, SPEnable, PopData, Done, StackErr
  );

  modport slave (
    output Req, ReqOp, ReqData, SPValue, MemAck, MemRData,
    input  Ready, Stall, MemReq, MemWrite, MemAddr, MemWData,
           SP_OP, SPEnable, PopData, Done, StackErr
  );
endinterface

// File: rtl/stack_seq_controller.sv
// stack_seq_controller: sequences PUSH16/POP16/PUSH32/POP32 requests into
// 16-bit memory transactions on a down-growing stack and pulses the
// stack-pointer block once per acknowledged word.
// Optional feature: define STACK_BOUND_CHECK_EN to reject requests whose
// word range falls outside [SP_LIMIT, SP_TOP]; such requests finish
// immediately with Done and StackErr and touch neither memory nor SP.
module stack_seq_controller #(
  parameter logic [31:0] SP_TOP   = 32'h0000_0FFF,
  parameter logic [31:0] SP_LIMIT = 32'h0000_0800
) (
  input  logic                   CLK,
  input  logic                   Reset,
  stack_seq_controller_if.master bus
);

  // ReqOp encoding: bit 0 = pop, bit 1 = 32-bit
  localparam logic [1:0] SPOP_HOLD = 2'b00;
  localparam logic [1:0] SPOP_DEC  = 2'b01;
  localparam logic [1:0] SPOP_INC  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER0 = 2'd1,
    XFER1 = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_reg;

  // Request latched at accept; addresses come from base_reg only, so a
  // moving SPValue during the operation cannot skew the second word.
  logic [1:0]  op_reg;
  logic [31:0] data_reg;
  logic [31:0] base_reg;

  // Registered outputs
  logic        ready_reg;
  logic        stall_reg;
  logic        mem_req_reg;
  logic        mem_write_reg;
  logic [31:0] mem_addr_reg;
  logic [15:0] mem_wdata_reg;
  logic [31:0] pop_data_reg;
  logic        done_reg;
  logic        err_reg;

  logic        mem_fire;
  logic        range_err;

  // Address of word k: push walks down from Base, pop starts one above Base.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic        is_pop,
                                            input logic        second);
    if (is_pop)
      word_addr = base + 32'd1 + {31'd0, second};
    else
      word_addr = base - {31'd0, second};
  endfunction

  // A word completes when the memory acknowledges an outstanding request.
  // Reset masks it so an interrupted op never moves SP on the reset edge.
  assign mem_fire = mem_req_reg & bus.MemAck & ~Reset;

`ifdef STACK_BOUND_CHECK_EN
  // Range check on the live request, evaluated in 33 bits so that
  // Base-1 or Base+2 cannot wrap around the address space.
  always_comb begin
    range_err = 1'b0;
    if (bus.ReqOp[0])
      range_err = ({1'b0, bus.SPValue} + (bus.ReqOp[1] ? 33'd2 : 33'd1))
                  > {1'b0, SP_TOP};
    else
      range_err = {1'b0, bus.SPValue}
                  < ({1'b0, SP_LIMIT} + (bus.ReqOp[1] ? 33'd1 : 33'd0));
  end
`else
  logic unused_bound_params;
  assign range_err           = 1'b0;
  assign unused_bound_params = ^{SP_TOP, SP_LIMIT};
`endif

  // Sequencer FSM: accept, one or two memory words, one-cycle completion.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg     <= IDLE;
      op_reg        <= 2'b00;
      data_reg      <= 32'd0;
      base_reg      <= 32'd0;
      ready_reg     <= 1'b1;
      stall_reg     <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_write_reg <= 1'b0;
      mem_addr_reg  <= 32'd0;
      mem_wdata_reg <= 16'd0;
      pop_data_reg  <= 32'd0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses
      done_reg <= 1'b0;
      err_reg  <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (bus.Req) begin
            op_reg    <= bus.ReqOp;
            data_reg  <= bus.ReqData;
            base_reg  <= bus.SPValue;
            ready_reg <= 1'b0;
            stall_reg <= 1'b1;
            if (range_err) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
              err_reg   <= 1'b1;
            end else begin
              state_reg     <= XFER0;
              mem_req_reg   <= 1'b1;
              mem_write_reg <= ~bus.ReqOp[0];
              mem_addr_reg  <= word_addr(bus.SPValue, bus.ReqOp[0], 1'b0);
              // PUSH32 sends the high half first so it lands at the higher address
              if (!bus.ReqOp[0])
                mem_wdata_reg <= bus.ReqOp[1] ? bus.ReqData[31:16]
                                              : bus.ReqData[15:0];
            end
          end
        end

        XFER0: begin
          if (mem_req_reg && bus.MemAck) begin
            if (op_reg[0]) begin
              // First popped word is the low half (or the whole POP16 value)
              if (op_reg[1])
                pop_data_reg[15:0] <= bus.MemRData;
              else
                pop_data_reg <= {16'd0, bus.MemRData};
            end
            if (op_reg[1]) begin
              // Second word issued back-to-back; MemReq stays high
              state_reg    <= XFER1;
              mem_addr_reg <= word_addr(base_reg, op_reg[0], 1'b1);
              if (!op_reg[0])
                mem_wdata_reg <= data_reg[15:0];
            end else begin
              state_reg   <= DONE;
              mem_req_reg <= 1'b0;
              done_reg    <= 1'b1;
            end
          end
        end

        XFER1: begin
          if (mem_req_reg && bus.MemAck) begin
            if (op_reg[0])
              pop_data_reg[31:16] <= bus.MemRData;
            state_reg   <= DONE;
            mem_req_reg <= 1'b0;
            done_reg    <= 1'b1;
          end
        end

        DONE: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
          stall_reg <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
          stall_reg <= 1'b0;
        end
      endcase
    end
  end

  // Output mapping; SP controls follow MemAck within the same cycle.
  assign bus.Ready    = ready_reg;
  assign bus.Stall    = stall_reg;
  assign bus.MemReq   = mem_req_reg;
  assign bus.MemWrite = mem_write_reg;
  assign bus.MemAddr  = mem_addr_reg;
  assign bus.MemWData = mem_wdata_reg;
  assign bus.PopData  = pop_data_reg;
  assign bus.Done     = done_reg;
  assign bus.StackErr = err_reg;
  assign bus.SPEnable = mem_fire;
  assign bus.SP_OP    = mem_fire ? (mem_write_reg ? SPOP_DEC : SPOP_INC)
                                 : SPOP_HOLD;

endmodule

// File: tb/tb_stack_seq_controller.sv
// Directed testbench for stack_seq_controller. Acts as execute stage and
// data memory; logs every acknowledged word and SP pulse on the falling edge.
module tb_stack_seq_controller;

  logic CLK;
  logic Reset;

  stack_seq_controller_if bus();

  stack_seq_controller dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests_run = 0;
  int tests_failed = 0;

  // Transaction logs, cleared before each operation
  logic [31:0] addr_q[$];
  logic [15:0] wdata_q[$];
  logic        we_q[$];
  logic [1:0]  spop_q[$];
  int          memreq_cycles;
  int          spop_idle_bad;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    addr_q.delete();
    wdata_q.delete();
    we_q.delete();
    spop_q.delete();
    memreq_cycles = 0;
    spop_idle_bad = 0;
  endtask

  // Falling-edge monitor
  always @(negedge CLK) begin
    if (bus.MemReq) memreq_cycles++;
    if (bus.MemReq && bus.MemAck) begin
      addr_q.push_back(bus.MemAddr);
      wdata_q.push_back(bus.MemWData);
      we_q.push_back(bus.MemWrite);
    end
    if (bus.SPEnable) spop_q.push_back(bus.SP_OP);
    else if (bus.SP_OP != 2'b00) spop_idle_bad++;
  end

  // Issue one request and play memory until Done or the cycle budget runs out.
  // lat = cycles from accept edge to the cycle showing Done.
  task automatic do_op(input logic [1:0] op, input logic [31:0] data,
                       input logic [31:0] sp, input int waits,
                       input logic [15:0] rd0, input logic [15:0] rd1,
                       output int lat, output int stall_bad,
                       output logic err_seen);
    int waitcnt;
    int word;
    clear_logs();
    bus.Req     = 1'b1;
    bus.ReqOp   = op;
    bus.ReqData = data;
    bus.SPValue = sp;
    @(posedge CLK); #1;
    bus.Req     = 1'b0;
    bus.SPValue = 32'hDEAD_BEEF;   // base must already be latched
    lat = 1;
    waitcnt = 0;
    word = 0;
    stall_bad = 0;
    while (!bus.Done && lat < 50) begin
      if (!bus.Stall || bus.Ready) stall_bad++;
      if (bus.MemReq) begin
        if (waitcnt == waits) begin
          bus.MemAck   = 1'b1;
          bus.MemRData = (word == 0) ? rd0 : rd1;
          waitcnt = 0;
          word++;
        end else begin
          bus.MemAck = 1'b0;
          waitcnt++;
        end
      end
      @(posedge CLK); #1;
      bus.MemAck   = 1'b0;
      bus.MemRData = 16'h0000;
      lat++;
    end
    err_seen = bus.StackErr;
    $display("[TB] op=%b data=%h sp=%h waits=%0d lat=%0d words=%0d pop=%h err=%b",
             op, data, sp, waits, lat, addr_q.size(), bus.PopData, err_seen);
    // Done must last one cycle and return to IDLE
    @(posedge CLK); #1;
    check("done_pulse_len", 32'(bus.Done), 32'd0);
    check("ready_after", 32'(bus.Ready), 32'd1);
  endtask

  int          lat;
  int          stall_bad;
  logic        err_seen;
  logic [31:0] pop_before;

  initial begin
    Reset        = 1'b1;
    bus.Req      = 1'b0;
    bus.ReqOp    = 2'b00;
    bus.ReqData  = 32'd0;
    bus.SPValue  = 32'd0;
    bus.MemAck   = 1'b0;
    bus.MemRData = 16'd0;
    clear_logs();

    // Reset held two cycles
    @(posedge CLK); @(posedge CLK); #1;
    Reset = 1'b0;
    check("rst_ready",    32'(bus.Ready),    32'd1);
    check("rst_stall",    32'(bus.Stall),    32'd0);
    check("rst_memreq",   32'(bus.MemReq),   32'd0);
    check("rst_memwrite", 32'(bus.MemWrite), 32'd0);
    check("rst_spen",     32'(bus.SPEnable), 32'd0);
    check("rst_done",     32'(bus.Done),     32'd0);
    check("rst_err",      32'(bus.StackErr), 32'd0);
    check("rst_addr",     bus.MemAddr,       32'd0);
    check("rst_wdata",    32'(bus.MemWData), 32'd0);
    check("rst_pop",      bus.PopData,       32'd0);
    check("rst_spop",     32'(bus.SP_OP),    32'd0);
    $display("[TB] reset released, Ready=%b", bus.Ready);

    // PUSH16 at 0x0FFF, zero wait
    do_op(2'b00, 32'h0000_ABCD, 32'h0000_0FFF, 0, 16'h0, 16'h0,
          lat, stall_bad, err_seen);
    check("p16_lat",    32'(lat),            32'd2);
    check("p16_words",  32'(addr_q.size()),  32'd1);
    check("p16_addr",   addr_q[0],           32'h0000_0FFF);
    check("p16_wdata",  32'(wdata_q[0]),     32'h0000_ABCD);
    check("p16_we",     32'(we_q[0]),        32'd1);
    check("p16_pulses", 32'(spop_q.size()),  32'd1);
    check("p16_spop",   32'(spop_q[0]),      32'd1);
    check("p16_err",    32'(err_seen),       32'd0);
    check("p16_pop",    bus.PopData,         32'd0);

    // PUSH32 at 0x0FFF, two wait cycles per word
    do_op(2'b10, 32'h1234_5678, 32'h0000_0FFF, 2, 16'h0, 16'h0,
          lat, stall_bad, err_seen);
    check("p32_lat",    32'(lat),            32'd7);
    check("p32_words",  32'(addr_q.size()),  32'd2);
    check("p32_addr0",  addr_q[0],           32'h0000_0FFF);
    check("p32_wdata0", 32'(wdata_q[0]),     32'h0000_1234);
    check("p32_addr1",  addr_q[1],           32'h0000_0FFE);
    check("p32_wdata1", 32'(wdata_q[1]),     32'h0000_5678);
    check("p32_we1",    32'(we_q[1]),        32'd1);
    check("p32_pulses", 32'(spop_q.size()),  32'd2);
    check("p32_spop0",  32'(spop_q[0]),      32'd1);
    check("p32_spop1",  32'(spop_q[1]),      32'd1);
    check("p32_stall",  32'(stall_bad),      32'd0);
    check("p32_reqcyc", 32'(memreq_cycles),  32'd6);

    // POP32 at 0x0FFD, zero wait
    do_op(2'b11, 32'h0, 32'h0000_0FFD, 0, 16'h5678, 16'h1234,
          lat, stall_bad, err_seen);
    check("o32_lat",    32'(lat),            32'd3);
    check("o32_addr0",  addr_q[0],           32'h0000_0FFE);
    check("o32_addr1",  addr_q[1],           32'h0000_0FFF);
    check("o32_we0",    32'(we_q[0]),        32'd0);
    check("o32_pulses", 32'(spop_q.size()),  32'd2);
    check("o32_spop0",  32'(spop_q[0]),      32'd2);
    check("o32_spop1",  32'(spop_q[1]),      32'd2);
    check("o32_pop",    bus.PopData,         32'h1234_5678);

    // POP16 zero-extends
    do_op(2'b01, 32'h0, 32'h0000_0900, 1, 16'hBEEF, 16'h0,
          lat, stall_bad, err_seen);
    check("o16_lat",    32'(lat),            32'd3);
    check("o16_addr",   addr_q[0],           32'h0000_0901);
    check("o16_pop",    bus.PopData,         32'h0000_BEEF);

    // PopData holds across a push
    do_op(2'b00, 32'hFFFF_0001, 32'h0000_0A00, 0, 16'h0, 16'h0,
          lat, stall_bad, err_seen);
    check("hold_wdata", 32'(wdata_q[0]),     32'h0000_0001);
    check("hold_pop",   bus.PopData,         32'h0000_BEEF);

    // Reset while waiting in XFER1 of a PUSH32
    clear_logs();
    bus.Req     = 1'b1;
    bus.ReqOp   = 2'b10;
    bus.ReqData = 32'hCAFE_F00D;
    bus.SPValue = 32'h0000_0FFF;
    @(posedge CLK); #1;
    bus.Req    = 1'b0;
    bus.MemAck = 1'b1;                   // word 0 acked immediately
    @(posedge CLK); #1;
    bus.MemAck = 1'b0;
    @(posedge CLK); #1;
    check("rmid_memreq", 32'(bus.MemReq),  32'd1);
    check("rmid_addr",   bus.MemAddr,      32'h0000_0FFE);
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    check("rmid_memreq_drop", 32'(bus.MemReq), 32'd0);
    check("rmid_ready",       32'(bus.Ready),  32'd1);
    check("rmid_stall",       32'(bus.Stall),  32'd0);
    @(posedge CLK); #1;
    check("rmid_pulses",      32'(spop_q.size()), 32'd1);
    $display("[TB] reset mid-PUSH32: pulses=%0d MemReq=%b Ready=%b",
             spop_q.size(), bus.MemReq, bus.Ready);

    // POP16 at the top of the stack
    pop_before = bus.PopData;
    do_op(2'b01, 32'h0, 32'h0000_0FFF, 0, 16'h4242, 16'h0,
          lat, stall_bad, err_seen);
`ifdef STACK_BOUND_CHECK_EN
    check("bnd_lat",     32'(lat),           32'd1);
    check("bnd_err",     32'(err_seen),      32'd1);
    check("bnd_memreq",  32'(memreq_cycles), 32'd0);
    check("bnd_pulses",  32'(spop_q.size()), 32'd0);
    check("bnd_pop",     bus.PopData,        pop_before);
`else
    check("bnd_lat",     32'(lat),           32'd2);
    check("bnd_err",     32'(err_seen),      32'd0);
    check("bnd_addr",    addr_q[0],          32'h0000_1000);
    check("bnd_pop",     bus.PopData,        32'h0000_4242);
`endif

    check("spop_idle_zero", 32'(spop_idle_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
